conv_tile_bram_server: RTL and testbench
========================================

Name: conv_tile_bram_server

Overview:
- Memory-side responder for the ConvTop engine.
- Holds one tile of input pixels and weights, loaded by a host port, and starts the engine with a one-cycle ready pulse.
- Answers the engine's read_en/bram_rd_addr requests with data plus a valid strobe, and captures write_en/bram_wr_addr output pixels into an output buffer.
- The host reads results back after the engine signals tile_done.

Parameters:
- DW, 128, data width of pixel, weight and output words.
- IN_DEPTH, 256, entries in each of the pixel and weight buffers.
- OUT_DEPTH, 256, entries in the output buffer.
- AW, 8, host address width, equal to clog2(max(IN_DEPTH, OUT_DEPTH)).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- host_wr_en  in  1  host write strobe.
- host_wr_sel  in  1  0 selects the pixel buffer, 1 selects the weight buffer.
- host_wr_addr  in  AW  host write address.
- host_wr_data  in  DW  host write data.
- host_start  in  1  request to start one tile.
- host_rd_en  in  1  output-buffer read strobe.
- host_rd_addr  in  AW  output-buffer read address.
- host_rd_data  out  DW  output-buffer read data.
- host_rd_valid  out  1  host_rd_data is valid this cycle.
- ready  out  1  start pulse to the engine.
- read_en  in  1  engine read request.
- bram_rd_addr  in  32  engine read address.
- input_pixels  out  DW  pixel word returned to the engine.
- weights  out  DW  weight word returned to the engine.
- valid  out  1  input_pixels and weights are valid this cycle.
- write_en  in  1  engine write request.
- bram_wr_addr  in  32  engine write address.
- output_pixels  in  DW  engine write data.
- tile_done  in  1  engine has finished the tile.
- busy  out  1  state is START or RUN.
- done  out  1  state is DONE.
- err  out  1  sticky protocol/range error.
- wr_count  out  16  number of engine writes accepted in the current tile.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - ready, valid, host_rd_valid, busy, done, err = 0.
  - input_pixels, weights, host_rd_data = 0; wr_count = 0.
  - Buffer contents are not cleared.
  - Reset asserted mid-RUN aborts the tile immediately; no further valid pulses are issued.
- States: IDLE, START, RUN, DONE.
  - IDLE: host_start moves to START.
  - START: lasts exactly one cycle with ready=1; wr_count is cleared; the next state is RUN.
  - RUN: tile_done=1 moves to DONE. host_start is ignored.
  - DONE: done=1. host_start moves to START for a new tile, giving back-to-back tiles.
- Engine read path, RUN only, fixed latency 1:
  - read_en sampled at edge N produces valid=1 for exactly one cycle after edge N+1.
  - input_pixels = pix_mem[addr] and weights = wgt_mem[addr], where addr = bram_rd_addr[AW-1:0].
  - Data holds its value until the next read; valid does not.
  - bram_rd_addr >= IN_DEPTH: returns 0 on both outputs, valid still pulses, err is set.
  - read_en outside RUN: ignored, no valid pulse, err is set.
  - read_en asserted on consecutive cycles gives valid on consecutive cycles (full throughput).
- Engine write path, RUN only:
  - write_en writes out_mem[bram_wr_addr[AW-1:0]] = output_pixels and increments wr_count, saturating at 0xFFFF.
  - bram_wr_addr >= OUT_DEPTH: write dropped, wr_count not incremented, err is set.
  - write_en outside RUN: dropped, err is set.
- Simultaneous events:
  - read_en together with tile_done in the same cycle: the read is still serviced; valid pulses in the first DONE cycle.
  - write_en together with tile_done: the write is accepted.
  - read_en and write_en in the same cycle are independent.
- Host write path:
  - Accepted only in IDLE or DONE.
  - Writes to the buffer chosen by host_wr_sel.
  - Address >= IN_DEPTH, or a write during START/RUN: dropped, err is set.
- Host read path:
  - Allowed in any state, latency 1.
  - host_rd_en at edge N gives host_rd_valid=1 and host_rd_data=out_mem[host_rd_addr] after edge N+1.
  - Address >= OUT_DEPTH returns 0 with host_rd_valid=1.
- err is sticky; it clears only on reset or on entry to START.

Test Plan:
- Load pix[i]=i, wgt[i]=~i for i=0..7; host_start; engine issues read_en addr 0..7 back-to-back → ready pulses 1 cycle after host_start; valid pulses 8 consecutive cycles; data = {i, ~i}, each one cycle after its request; err=0.
- Engine writes out[j]=j*3 for j=0..8, then tile_done → wr_count=9, done=1; host reads addr 0..8 → host_rd_data=j*3 with 1-cycle latency.
- bram_rd_addr=300 (IN_DEPTH=256) → valid=1, input_pixels=0, weights=0, err=1; next host_start clears err.
- read_en and tile_done in the same cycle with addr 5 → valid=1 with pix[5] in the first DONE cycle; no later valid.
- Host write in RUN, and write_en in IDLE → both dropped, buffers unchanged, err=1.
- rst_n pulled low mid-RUN with read_en active → all outputs 0 asynchronously, state IDLE; after release, host_start yields a fresh ready pulse and preloaded data is intact.

Source files
------------

// File: rtl/conv_tile_bram_server.sv
// rtl/conv_tile_bram_server.sv - tile buffer server between a host port and the ConvTop engine
// Holds pixel/weight/output tiles and sequences IDLE -> START -> RUN -> DONE.
module conv_tile_bram_server #(
    parameter int DW        = 128,
    parameter int IN_DEPTH  = 256,
    parameter int OUT_DEPTH = 256,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_wr_en,
    input  logic          host_wr_sel,
    input  logic [AW-1:0] host_wr_addr,
    input  logic [DW-1:0] host_wr_data,
    input  logic          host_start,
    input  logic          host_rd_en,
    input  logic [AW-1:0] host_rd_addr,
    output logic [DW-1:0] host_rd_data,
    output logic          host_rd_valid,
    output logic          ready,
    input  logic          read_en,
    input  logic [31:0]   bram_rd_addr,
    output logic [DW-1:0] input_pixels,
    output logic [DW-1:0] weights,
    output logic          valid,
    input  logic          write_en,
    input  logic [31:0]   bram_wr_addr,
    input  logic [DW-1:0] output_pixels,
    input  logic          tile_done,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   wr_count
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_e;

    localparam logic [31:0] IN_LIM  = IN_DEPTH;
    localparam logic [31:0] OUT_LIM = OUT_DEPTH;

    logic [DW-1:0] pix_mem [IN_DEPTH];
    logic [DW-1:0] wgt_mem [IN_DEPTH];
    logic [DW-1:0] out_mem [OUT_DEPTH];

    state_e        state_q, state_d;
    logic          err_q, err_d;
    logic [15:0]   wr_count_q, wr_count_d;
    logic          valid_q;
    logic [DW-1:0] pix_q, wgt_q;
    logic          host_rd_valid_q;
    logic [DW-1:0] host_rd_data_q;

    logic [31:0] host_wr_addr_ext, host_rd_addr_ext;
    logic        in_run, host_ok;
    logic        rd_in_range, wr_in_range, hw_in_range, hr_in_range;
    logic        rd_accept, wr_accept, hw_accept, err_evt;

    assign host_wr_addr_ext = 32'(host_wr_addr);
    assign host_rd_addr_ext = 32'(host_rd_addr);

    assign in_run      = (state_q == S_RUN);
    assign host_ok     = (state_q == S_IDLE) || (state_q == S_DONE);
    assign rd_in_range = (bram_rd_addr < IN_LIM);
    assign wr_in_range = (bram_wr_addr < OUT_LIM);
    assign hw_in_range = (host_wr_addr_ext < IN_LIM);
    assign hr_in_range = (host_rd_addr_ext < OUT_LIM);

    assign rd_accept = read_en && in_run;
    assign wr_accept = write_en && in_run && wr_in_range;
    assign hw_accept = host_wr_en && host_ok && hw_in_range;

    // Out-of-range reads still pulse valid (with zero data) but flag the error.
    assign err_evt = (read_en && !(in_run && rd_in_range))
                   || (write_en && !wr_accept)
                   || (host_wr_en && !hw_accept);

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        case (state_q)
            S_IDLE:  if (host_start) state_d = S_START;
            S_START: state_d = S_RUN;
            S_RUN:   if (tile_done) state_d = S_DONE;
            S_DONE:  if (host_start) state_d = S_START;
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_START) begin
            wr_count_d = '0;
        end else if (wr_accept && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end

        // Entering START wipes the sticky error, even if an event coincides.
        err_d = (state_d == S_START) ? 1'b0 : (err_q | err_evt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            err_q           <= 1'b0;
            wr_count_q      <= '0;
            valid_q         <= 1'b0;
            pix_q           <= '0;
            wgt_q           <= '0;
            host_rd_valid_q <= 1'b0;
            host_rd_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            err_q           <= err_d;
            wr_count_q      <= wr_count_d;
            valid_q         <= rd_accept;
            host_rd_valid_q <= host_rd_en;
            if (rd_accept) begin
                pix_q <= rd_in_range ? pix_mem[bram_rd_addr[AW-1:0]] : '0;
                wgt_q <= rd_in_range ? wgt_mem[bram_rd_addr[AW-1:0]] : '0;
            end
            if (host_rd_en) begin
                host_rd_data_q <= hr_in_range ? out_mem[host_rd_addr] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hw_accept && !host_wr_sel) pix_mem[host_wr_addr] <= host_wr_data;
        if (hw_accept && host_wr_sel)  wgt_mem[host_wr_addr] <= host_wr_data;
        if (wr_accept)                 out_mem[bram_wr_addr[AW-1:0]] <= output_pixels;
    end

    assign ready         = (state_q == S_START);
    assign busy          = (state_q == S_START) || (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign wr_count      = wr_count_q;
    assign valid         = valid_q;
    assign input_pixels  = pix_q;
    assign weights       = wgt_q;
    assign host_rd_valid = host_rd_valid_q;
    assign host_rd_data  = host_rd_data_q;

endmodule

// File: tb/tb_conv_tile_bram_server.sv
// tb/tb_conv_tile_bram_server.sv - directed self-checking bench for conv_tile_bram_server
module tb_conv_tile_bram_server;

    localparam int DW = 128;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          host_wr_en, host_wr_sel, host_start, host_rd_en;
    logic [AW-1:0] host_wr_addr, host_rd_addr;
    logic [DW-1:0] host_wr_data, host_rd_data;
    logic          host_rd_valid, ready, read_en, valid, write_en, tile_done;
    logic [31:0]   bram_rd_addr, bram_wr_addr;
    logic [DW-1:0] input_pixels, weights, output_pixels;
    logic          busy, done, err;
    logic [15:0]   wr_count;

    int n_checks = 0;
    int n_errors = 0;

    conv_tile_bram_server #(.DW(DW), .IN_DEPTH(256), .OUT_DEPTH(256), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_wr_en(host_wr_en), .host_wr_sel(host_wr_sel), .host_wr_addr(host_wr_addr),
        .host_wr_data(host_wr_data), .host_start(host_start),
        .host_rd_en(host_rd_en), .host_rd_addr(host_rd_addr),
        .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid),
        .ready(ready), .read_en(read_en), .bram_rd_addr(bram_rd_addr),
        .input_pixels(input_pixels), .weights(weights), .valid(valid),
        .write_en(write_en), .bram_wr_addr(bram_wr_addr), .output_pixels(output_pixels),
        .tile_done(tile_done), .busy(busy), .done(done), .err(err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] inv(input int v);
        logic [DW-1:0] t;
        t = DW'(v);
        return ~t;
    endfunction

    initial begin
        rst_n = 1'b0;
        host_wr_en = 0; host_wr_sel = 0; host_wr_addr = '0; host_wr_data = '0;
        host_start = 0; host_rd_en = 0; host_rd_addr = '0;
        read_en = 0; bram_rd_addr = '0; write_en = 0; bram_wr_addr = '0;
        output_pixels = '0; tile_done = 0;
        tick(); tick();
        check("rst_ready", ready, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_pix", input_pixels, 0);
        check("rst_host_rd_valid", host_rd_valid, 0);
        rst_n = 1'b1;

        // Preload tile: pix[i]=i, wgt[i]=~i
        for (int i = 0; i < 8; i++) begin
            host_wr_en = 1; host_wr_sel = 0; host_wr_addr = AW'(i); host_wr_data = DW'(i);
            tick();
            host_wr_sel = 1; host_wr_data = inv(i);
            tick();
        end
        host_wr_en = 0;

        host_start = 1;
        tick();
        host_start = 0;
        check("start_ready", ready, 1);
        check("start_busy", busy, 1);
        tick();
        check("run_ready_low", ready, 0);

        for (int i = 0; i < 8; i++) begin
            read_en = 1; bram_rd_addr = i;
            tick();
            check($sformatf("rd_valid_%0d", i), valid, 1);
            check($sformatf("rd_pix_%0d", i), input_pixels, DW'(i));
            check($sformatf("rd_wgt_%0d", i), weights, inv(i));
        end
        read_en = 0;
        tick();
        check("rd_valid_end", valid, 0);
        check("rd_err_clean", err, 0);

        for (int j = 0; j < 9; j++) begin
            write_en = 1; bram_wr_addr = j; output_pixels = DW'(j * 3);
            tick();
        end
        write_en = 0;
        check("wr_count_9", wr_count, 16'd9);
        tile_done = 1;
        tick();
        tile_done = 0;
        check("done_set", done, 1);
        check("done_busy", busy, 0);

        for (int j = 0; j < 9; j++) begin
            host_rd_en = 1; host_rd_addr = AW'(j);
            tick();
            check($sformatf("hrd_valid_%0d", j), host_rd_valid, 1);
            check($sformatf("hrd_data_%0d", j), host_rd_data, DW'(j * 3));
        end
        host_rd_en = 0;
        tick();
        check("hrd_valid_end", host_rd_valid, 0);

        // Out-of-range engine read
        host_start = 1; tick(); host_start = 0; tick();
        check("tile2_wr_count", wr_count, 0);
        read_en = 1; bram_rd_addr = 300;
        tick();
        read_en = 0;
        check("oor_valid", valid, 1);
        check("oor_pix", input_pixels, 0);
        check("oor_wgt", weights, 0);
        check("oor_err", err, 1);
        tile_done = 1; tick(); tile_done = 0;
        host_start = 1; tick(); host_start = 0;
        check("start_clears_err", err, 0);
        tick();

        // Read coinciding with tile_done
        read_en = 1; bram_rd_addr = 5; tile_done = 1;
        tick();
        read_en = 0; tile_done = 0;
        check("rd_done_state", done, 1);
        check("rd_done_valid", valid, 1);
        check("rd_done_pix", input_pixels, DW'(5));
        check("rd_done_wgt", weights, inv(5));
        tick();
        check("rd_done_no_more", valid, 0);

        // Host write during RUN is dropped
        host_start = 1; tick(); host_start = 0; tick();
        host_wr_en = 1; host_wr_sel = 0; host_wr_addr = 8'd2; host_wr_data = 'hDEAD;
        tick();
        host_wr_en = 0;
        check("hw_run_err", err, 1);
        tile_done = 1; tick(); tile_done = 0;

        // Reset mid-RUN with a read in flight
        host_start = 1; tick(); host_start = 0; tick();
        read_en = 1; bram_rd_addr = 3;
        tick();
        check("pre_rst_pix", input_pixels, DW'(3));
        bram_rd_addr = 4;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", valid, 0);
        check("arst_pix", input_pixels, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", ready, 0);
        check("arst_err", err, 0);
        read_en = 0;
        tick();
        check("arst_held_valid", valid, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle_busy", busy, 0);
        check("post_rst_idle_done", done, 0);

        // Engine write in IDLE is dropped
        write_en = 1; bram_wr_addr = 1; output_pixels = 'hBEEF;
        tick();
        write_en = 0;
        check("we_idle_err", err, 1);
        host_rd_en = 1; host_rd_addr = 8'd1;
        tick();
        host_rd_en = 0;
        check("we_idle_out_kept", host_rd_data, DW'(3));

        host_start = 1; tick(); host_start = 0;
        check("restart_ready", ready, 1);
        check("restart_err_clear", err, 0);
        tick();
        read_en = 1; bram_rd_addr = 2;
        tick();
        read_en = 0;
        check("restart_valid", valid, 1);
        check("restart_pix_kept", input_pixels, DW'(2));
        check("restart_wgt_kept", weights, inv(2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
